// File: rtl/shift_seq.sv
// Multi-cycle x86 group-2 shift/rotate unit: one bit per clock on a
// size-restricted field, producing flags in the 12-bit ALU layout.
module shift_seq #(
    parameter int WIDTH      = 16,
    parameter bit MASK_COUNT = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [1:0]       size,
    input  logic [WIDTH-1:0] op1,
    input  logic [7:0]       count,
    input  logic [11:0]      flags,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] value,
    output logic [11:0]      flags_out,
    output logic [1:0]       dbg_state
);
    localparam int IW = $clog2(WIDTH);

    localparam logic [2:0] OP_ROL = 3'd0;
    localparam logic [2:0] OP_ROR = 3'd1;
    localparam logic [2:0] OP_RCL = 3'd2;
    localparam logic [2:0] OP_RCR = 3'd3;
    localparam logic [2:0] OP_SHR = 3'd5;
    localparam logic [2:0] OP_SAR = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [2:0]       op_q;
    logic [1:0]       size_q;
    logic [WIDTH-1:0] work_q;
    logic             cf_q;
    logic             omsb_q;
    logic [11:0]      flags_q;
    logic [7:0]       cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] value_q;
    logic [11:0]      flags_out_q;

    // Size 2 only exists on a 32-bit datapath; anything else non-byte is 16.
    function automatic logic [1:0] norm_size(input logic [1:0] s);
        if (s == 2'd0)                    return 2'd0;
        else if (s == 2'd2 && WIDTH == 32) return 2'd2;
        else                              return 2'd1;
    endfunction

    function automatic logic [WIDTH-1:0] mask_of(input logic [1:0] s);
        logic [WIDTH-1:0] m;
        m = '0;
        case (s)
            2'd0:    m[7:0]  = '1;
            2'd1:    m[15:0] = '1;
            default: m       = '1;
        endcase
        return m;
    endfunction

    function automatic logic [IW-1:0] msb_of(input logic [1:0] s);
        case (s)
            2'd0:    return IW'(7);
            2'd1:    return IW'(15);
            default: return IW'(WIDTH - 1);
        endcase
    endfunction

    logic [1:0]       start_size;
    logic [7:0]       start_n;
    logic [IW-1:0]    msb_idx;
    logic [IW-1:0]    msb1_idx;
    logic             in_bit;
    logic [WIDTH-1:0] step_val;
    logic             step_cf;
    logic [WIDTH-1:0] res_val;
    logic             res_cf;
    logic             res_msb;
    logic             res_of;
    logic [11:0]      res_flags;

    always_comb begin
        start_size = norm_size(size);
        start_n    = MASK_COUNT ? {3'b000, count[4:0]} : count;
        msb_idx    = msb_of(size_q);
        msb1_idx   = msb_idx - IW'(1);

        case (op_q)
            OP_ROL, OP_SAR: in_bit = work_q[msb_idx];
            OP_ROR:         in_bit = work_q[0];
            OP_RCL, OP_RCR: in_bit = cf_q;
            default:        in_bit = 1'b0;
        endcase

        // Even opcodes shift left, odd ones shift right.
        step_val = '0;
        if (!op_q[0]) begin
            step_val = ((work_q << 1) | {{(WIDTH-1){1'b0}}, in_bit}) & mask_of(size_q);
            step_cf  = work_q[msb_idx];
        end else begin
            step_val          = work_q >> 1;
            step_val[msb_idx] = in_bit;
            step_cf           = work_q[0];
        end

        // A zero count reaches the final cycle without having stepped.
        res_val = (cnt_q != 8'd0) ? step_val : work_q;
        res_cf  = (cnt_q != 8'd0) ? step_cf  : cf_q;
        res_msb = res_val[msb_idx];

        case (op_q)
            OP_ROR, OP_RCR: res_of = res_msb ^ res_val[msb1_idx];
            OP_SHR:         res_of = omsb_q;
            OP_SAR:         res_of = 1'b0;
            default:        res_of = res_msb ^ res_cf;
        endcase

        res_flags     = flags_q;
        res_flags[0]  = res_cf;
        res_flags[1]  = 1'b1;
        res_flags[3]  = 1'b0;
        res_flags[5]  = 1'b0;
        res_flags[11] = res_of;
        if (op_q[2]) begin
            res_flags[2] = ~^res_val[7:0];
            res_flags[4] = 1'b0;
            res_flags[6] = (res_val == '0);
            res_flags[7] = res_msb;
        end
        if (cnt_q == 8'd0) begin
            res_flags = flags_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            size_q      <= '0;
            work_q      <= '0;
            cf_q        <= 1'b0;
            omsb_q      <= 1'b0;
            flags_q     <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            value_q     <= '0;
            flags_out_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q    <= op;
                        size_q  <= start_size;
                        work_q  <= op1 & mask_of(start_size);
                        cf_q    <= flags[0];
                        omsb_q  <= op1[msb_of(start_size)];
                        flags_q <= flags;
                        cnt_q   <= start_n;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (cnt_q != 8'd0) begin
                        work_q <= step_val;
                        cf_q   <= step_cf;
                        cnt_q  <= cnt_q - 8'd1;
                    end
                    if (cnt_q <= 8'd1) begin
                        value_q     <= res_val;
                        flags_out_q <= res_flags;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign value     = value_q;
    assign flags_out = flags_out_q;
    assign dbg_state = state_q;
endmodule
